// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the i2c_temp master and the i2c_temp_responder target:
//   - i2c_state_e   : target-side protocol states
//   - REG_*         : register map addresses of the temperature sensor
//   - ACK_BIT/NACK_BIT, RW_READ/RW_WRITE : bus-level bit meanings
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_e;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_CONFIG   = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Synchronizes the raw SCL/SDA pins into the clk domain and produces
// single-cycle event pulses from the last two synchronized samples.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   scl_i,sda_i : raw bus pins
//   sda_o       : synchronized SDA level (data sampled by the FSM)
//   scl_rise    : SCL 0->1
//   scl_fall    : SCL 1->0
//   start_det   : SDA 1->0 while SCL stays high
//   stop_det    : SDA 0->1 while SCL stays high
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Bits [SYNC_STAGES-1:0] are the synchronizer chain; bit SYNC_STAGES holds
  // the previous synchronized sample used for edge detection.
  logic [SYNC_STAGES:0] scl_q, scl_d;
  logic [SYNC_STAGES:0] sda_q, sda_d;
  logic scl_now, scl_prev, sda_now, sda_prev;

  always_comb begin
    scl_d = {scl_q[SYNC_STAGES-1:0], scl_i};
    sda_d = {sda_q[SYNC_STAGES-1:0], sda_i};
  end

  // Reset to the idle-bus level so that leaving reset creates no false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_now  = scl_q[SYNC_STAGES-1];
  assign scl_prev = scl_q[SYNC_STAGES];
  assign sda_now  = sda_q[SYNC_STAGES-1];
  assign sda_prev = sda_q[SYNC_STAGES];

  assign sda_o     = sda_now;
  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  // SCL must be high in both samples so SDA moves during SCL low stay data.
  assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

endmodule

// File: rtl/i2c_temp_responder.sv
// -----------------------------------------------------------------------------
// i2c_temp_responder
// I2C target emulating the board temperature sensor register interface.
// Ports:
//   CLK100MHZ : system clock
//   btnC      : asynchronous active-high reset
//   I2C_SCL   : bus clock from the master (input only)
//   I2C_SDA   : open-drain bus data, driven 0 or released (z)
//   temp_in   : temperature word, [15:8] at reg 0x00, [7:0] at reg 0x01
//   cfg_out   : config register 0x03
//   busy      : address-matched transaction in progress (until STOP)
//   ack_cnt   : number of ACKs driven by this block, wraps
//   dbg_state : current protocol state
// -----------------------------------------------------------------------------
module i2c_temp_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h4B,
  parameter logic [7:0] DEVICE_ID   = 8'hCB,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK100MHZ,
  input  logic        btnC,
  input  logic        I2C_SCL,
  inout  wire         I2C_SDA,
  input  logic [15:0] temp_in,
  output logic [7:0]  cfg_out,
  output logic        busy,
  output logic [7:0]  ack_cnt,
  output i2c_state_e  dbg_state
);

  logic sda_in, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (CLK100MHZ),
    .rst      (btnC),
    .scl_i    (I2C_SCL),
    .sda_i    (I2C_SDA),
    .sda_o    (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [15:0] snap_q, snap_d;
  logic        busy_q, busy_d;
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  logic        sda_oe_q, sda_oe_d;
  logic        rd_mode_q, rd_mode_d;

  function automatic logic [7:0] reg_read(input logic [7:0] ptr,
                                          input logic [15:0] snap,
                                          input logic [7:0] cfg);
    case (ptr)
      REG_TEMP_MSB: reg_read = snap[15:8];
      REG_TEMP_LSB: reg_read = snap[7:0];
      REG_CONFIG:   reg_read = cfg;
      REG_ID:       reg_read = DEVICE_ID;
      default:      reg_read = 8'h00;
    endcase
  endfunction

  // The ACK states use bit_cnt as a phase flag: 0 = waiting for the SCL fall
  // after bit 8 (start ACK), 1 = waiting for the fall after bit 9 (end ACK).
  // shift_q doubles as receive shifter and transmit shifter; in RDATA the
  // bit being driven is always shift_q[7] at the time of the SCL fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    cfg_d     = cfg_q;
    snap_d    = snap_q;
    busy_d    = busy_q;
    ack_cnt_d = ack_cnt_q;
    sda_oe_d  = sda_oe_q;
    rd_mode_d = rd_mode_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_in};
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = (state_q == ST_ADDR) ? ST_ADDR_ACK :
                          (state_q == ST_PTR)  ? ST_PTR_ACK  : ST_WDATA_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              if (shift_q[7:1] == TARGET_ADDR) begin
                sda_oe_d  = 1'b1;
                ack_cnt_d = ack_cnt_q + 8'd1;
                busy_d    = 1'b1;
                bit_cnt_d = 4'd1;
                rd_mode_d = (shift_q[0] == RW_READ);
                if (shift_q[0] == RW_READ) begin
                  // Snapshot keeps MSB/LSB of one transaction coherent.
                  snap_d  = temp_in;
                  shift_d = reg_read(ptr_q, temp_in, cfg_q);
                end
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              bit_cnt_d = '0;
              if (rd_mode_q) begin
                // ACK release and first data bit share this falling edge.
                state_d  = ST_RDATA;
                sda_oe_d = ~shift_q[7];
                shift_d  = {shift_q[6:0], 1'b0};
              end else begin
                state_d  = ST_PTR;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        ST_PTR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              ack_cnt_d = ack_cnt_q + 8'd1;
              ptr_d     = shift_q;
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_WDATA;
            end
          end
        end

        ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              ack_cnt_d = ack_cnt_q + 8'd1;
              if (ptr_q == REG_CONFIG) cfg_d = shift_q;
              ptr_d     = ptr_q + 8'd1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              // Release for the master's ACK/NACK slot.
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RDATA_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_in == ACK_BIT) begin
              ptr_d     = ptr_q + 8'd1;
              shift_d   = reg_read(ptr_q + 8'd1, snap_q, cfg_q);
              bit_cnt_d = '0;
              state_d   = ST_RDATA;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge btnC) begin
    if (btnC) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= 8'h00;
      cfg_q     <= 8'h00;
      snap_q    <= '0;
      busy_q    <= 1'b0;
      ack_cnt_q <= '0;
      sda_oe_q  <= 1'b0;
      rd_mode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      cfg_q     <= cfg_d;
      snap_q    <= snap_d;
      busy_q    <= busy_d;
      ack_cnt_q <= ack_cnt_d;
      sda_oe_q  <= sda_oe_d;
      rd_mode_q <= rd_mode_d;
    end
  end

  // Open drain: only ever pull low.
  assign I2C_SDA   = sda_oe_q ? 1'b0 : 1'bz;
  assign cfg_out   = cfg_q;
  assign busy      = busy_q;
  assign ack_cnt   = ack_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// -----------------------------------------------------------------------------
// tb_i2c_temp_responder
// Bit-banged I2C master driving the responder, with a transaction-level
// model of the sensor register file predicting ACKs, read bytes and outputs.
// -----------------------------------------------------------------------------
module tb_i2c_temp_responder;
  import i2c_pkg::*;

  localparam int         Q   = 100;     // quarter SCL period
  localparam logic [6:0] TGT = 7'h4B;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        m_sda_oe;
  wire         sda;
  logic [15:0] temp_in;
  logic [7:0]  cfg_out;
  logic        busy;
  logic [7:0]  ack_cnt;
  i2c_state_e  dbg_state;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  i2c_temp_responder dut (
    .CLK100MHZ(clk),
    .btnC     (rst),
    .I2C_SCL  (scl),
    .I2C_SDA  (sda),
    .temp_in  (temp_in),
    .cfg_out  (cfg_out),
    .busy     (busy),
    .ack_cnt  (ack_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and model state
  int          n_checks = 0;
  int          n_fail   = 0;
  string       phase    = "init";
  logic [7:0]  exp_q[$];
  logic [7:0]  m_ptr, m_cfg, m_ack_cnt;
  logic [15:0] m_snap;
  logic        m_busy;
  int          dut_low_cnt = 0;

  // Counts cycles where SDA is low while the master is not pulling it.
  always @(posedge clk) if (!m_sda_oe && sda === 1'b0) dut_low_cnt++;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%s] got=0x%0h exp=0x%0h", tag, phase, got, exp);
    end
  endtask

  function automatic logic [7:0] model_reg(input logic [7:0] p);
    if (p == 8'h00) return m_snap[15:8];
    if (p == 8'h01) return m_snap[7:0];
    if (p == 8'h03) return m_cfg;
    if (p == 8'h0B) return 8'hCB;
    return 8'h00;
  endfunction

  // driver tasks: each bit starts and ends with SCL low
  task automatic bit_out(input logic drive_low);
    #Q m_sda_oe = drive_low;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic bit_in(input logic drive_low, output logic sampled);
    #Q m_sda_oe = drive_low;
    #Q scl = 1'b1;
    #Q sampled = sda;
    #Q scl = 1'b0;
  endtask

  task automatic bus_start();
    #Q m_sda_oe = 1'b0;
    #Q scl = 1'b1;
    #Q m_sda_oe = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q m_sda_oe = 1'b1;
    #Q scl = 1'b1;
    #Q m_sda_oe = 1'b0;
    #Q;
  endtask

  task automatic master_tx(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(~b[i]);
    bit_in(1'b0, ack);
  endtask

  task automatic master_rx(input logic give_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_in(1'b0, s);
      b[i] = s;
    end
    bit_out(give_ack);
  endtask

  // transaction-level steps, each updating the model
  task automatic send_addr(input logic [6:0] a, input logic rw);
    logic ack;
    logic matched;
    master_tx({a, rw}, ack);
    matched = (a == TGT);
    if (matched) begin
      m_ack_cnt++;
      m_busy = 1'b1;
      if (rw == RW_READ) m_snap = temp_in;
    end
    check_eq("addr_ack", ack, matched ? ACK_BIT : NACK_BIT);
    check_eq("busy_after_addr", busy, m_busy);
  endtask

  task automatic send_wbyte(input logic [7:0] b, input logic is_ptr);
    logic ack;
    master_tx(b, ack);
    check_eq("wr_ack", ack, ACK_BIT);
    m_ack_cnt++;
    if (is_ptr) m_ptr = b;
    else begin
      if (m_ptr == 8'h03) m_cfg = b;
      m_ptr++;
    end
  endtask

  task automatic recv_rbyte(input logic give_ack);
    logic [7:0] got;
    exp_q.push_back(model_reg(m_ptr));
    master_rx(give_ack, got);
    check_eq("rd_byte", got, exp_q.pop_front());
    if (give_ack) m_ptr++;
  endtask

  task automatic end_txn();
    bus_stop();
    m_busy = 1'b0;
    #(4*Q);
    check_eq("busy_after_stop", busy, m_busy);
    check_eq("ack_cnt", ack_cnt, m_ack_cnt);
    check_eq("cfg_out", cfg_out, m_cfg);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) recv_rbyte(i != n - 1);
  endtask

  task automatic set_ptr_then_read(input logic [7:0] p, input int n);
    bus_start();
    send_addr(TGT, RW_WRITE);
    send_wbyte(p, 1'b1);
    bus_start();
    send_addr(TGT, RW_READ);
    read_n(n);
    end_txn();
  endtask

  function automatic logic [7:0] pick_ptr();
    logic [7:0] tbl [0:5];
    int k;
    tbl[0] = 8'h00; tbl[1] = 8'h01; tbl[2] = 8'h02;
    tbl[3] = 8'h03; tbl[4] = 8'h0B; tbl[5] = 8'hFF;
    k = $urandom_range(0, 6);
    if (k == 6) return 8'($urandom_range(0, 255));
    return tbl[k];
  endfunction

  // watchdog
  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog [%s] got=timeout exp=finish", phase);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic s;
    int kind;
    int n;
    logic [6:0] a;

    rst = 1'b1; scl = 1'b1; m_sda_oe = 1'b0; temp_in = 16'h0000;
    m_ptr = 8'h00; m_cfg = 8'h00; m_ack_cnt = 8'h00; m_snap = '0; m_busy = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;

    phase = "reset_idle";
    #1000;
    check_eq("sda_idle", sda, 1'b1);
    check_eq("busy_rst", busy, 1'b0);
    check_eq("cfg_rst", cfg_out, 8'h00);
    check_eq("ack_cnt_rst", ack_cnt, 8'h00);
    check_eq("state_rst", dbg_state, ST_IDLE);

    phase = "write_cfg";
    bus_start();
    send_addr(TGT, RW_WRITE);
    send_wbyte(8'h03, 1'b1);
    send_wbyte(8'h80, 1'b0);
    end_txn();
    check_eq("cfg_is_80", cfg_out, 8'h80);
    check_eq("ack_cnt_is_3", ack_cnt, 8'd3);

    phase = "read_temp";
    temp_in = 16'h0C80;
    set_ptr_then_read(8'h00, 2);

    phase = "coherency";
    bus_start();
    send_addr(TGT, RW_WRITE);
    send_wbyte(8'h00, 1'b1);
    bus_start();
    send_addr(TGT, RW_READ);
    recv_rbyte(1'b1);
    temp_in = 16'h1234;
    recv_rbyte(1'b0);
    end_txn();
    set_ptr_then_read(8'h00, 2);

    phase = "wrong_addr";
    dut_low_cnt = 0;
    bus_start();
    send_addr(7'h48, RW_WRITE);
    end_txn();
    check_eq("no_dut_drive", dut_low_cnt, 0);

    phase = "id_and_wrap";
    temp_in = 16'h0C80;
    set_ptr_then_read(8'h0B, 3);
    set_ptr_then_read(8'hFF, 2);

    phase = "random";
    for (int t = 0; t < 10; t++) begin
      temp_in = 16'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          bus_start();
          send_addr(TGT, RW_WRITE);
          send_wbyte(pick_ptr(), 1'b1);
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) send_wbyte(8'($urandom_range(0, 255)), 1'b0);
          end_txn();
        end
        1: begin
          bus_start();
          send_addr(TGT, RW_READ);
          read_n($urandom_range(1, 3));
          end_txn();
        end
        2: set_ptr_then_read(pick_ptr(), $urandom_range(1, 3));
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == TGT) a = 7'h48;
          bus_start();
          send_addr(a, 1'($urandom_range(0, 1)));
          end_txn();
        end
      endcase
    end

    phase = "reset_mid_byte";
    bus_start();
    send_addr(TGT, RW_WRITE);
    send_wbyte(8'h02, 1'b1);
    bus_start();
    send_addr(TGT, RW_READ);
    bit_in(1'b0, s);
    bit_in(1'b0, s);
    #(2*Q);
    check_eq("dut_drives_zero", sda, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("sda_released_on_rst", sda, 1'b1);
    check_eq("state_idle_on_rst", dbg_state, ST_IDLE);
    check_eq("busy_on_rst", busy, 1'b0);
    check_eq("ack_cnt_on_rst", ack_cnt, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    m_ptr = 8'h00; m_cfg = 8'h00; m_ack_cnt = 8'h00; m_busy = 1'b0;
    end_txn();

    phase = "post_reset_read";
    temp_in = 16'hA55A;
    bus_start();
    send_addr(TGT, RW_READ);
    read_n(2);
    end_txn();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
